// File: rtl/exe_mul_unit_if.sv
// exe_mul_unit_if
// Groups the EXE-stage multiply request (operands, opcode bits, incoming
// status flags) and the response (busy stall, done pulse, result, flags,
// status write enable).
//   master : issuing side (decode/EXE control); drives the request and
//            samples the response
//   slave  : the multiply unit
interface exe_mul_unit_if #(
  parameter int WIDTH = 32
);
  // request
  logic             start;
  logic             accumulate;
  logic             s_bit;
  logic [WIDTH-1:0] op_rm;
  logic [WIDTH-1:0] op_rs;
  logic [WIDTH-1:0] op_rn;
  logic             c_in;
  logic             v_in;
  // response
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             N;
  logic             Z;
  logic             C;
  logic             V;
  logic             status_wb_en;

  modport master (
    output start, accumulate, s_bit, op_rm, op_rs, op_rn, c_in, v_in,
    input  busy, done, result, N, Z, C, V, status_wb_en
  );

  modport slave (
    input  start, accumulate, s_bit, op_rm, op_rs, op_rn, c_in, v_in,
    output busy, done, result, N, Z, C, V, status_wb_en
  );
endinterface

// File: rtl/exe_mul_unit.sv
// exe_mul_unit
// Multi-cycle radix-2 shift-and-add multiplier for MUL (Rd = Rm*Rs) and
// MLA (Rd = Rm*Rs + Rn). Produces the low WIDTH bits and N/Z/C/V flags.
// One partial product per cycle for WIDTH cycles, plus one cycle for the
// Rn add on MLA. C and V pass through unchanged from accept time.
// Ports:
//   clk  : pipeline clock
//   rst  : asynchronous active-low reset
//   mif  : exe_mul_unit_if.slave (request in, busy/done/result/flags out)
module exe_mul_unit #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          rst,
  exe_mul_unit_if.slave mif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_ACC, S_DONE} state_t;

  state_t           state, state_nxt;

  logic [WIDTH-1:0] acc, mcand, mplier, rn_l;
  logic [CW-1:0]    count;
  logic             acc_l, s_l, c_l, v_l;

  logic [WIDTH-1:0] res_q;
  logic             n_q, z_q, c_q, v_q;

  logic             accept, last_iter;
  logic [WIDTH-1:0] acc_mul, acc_fin;

  // A new op is only taken when nothing is in flight (IDLE) or the current
  // one is retiring (DONE); starts in MUL/ACC are dropped on the floor.
  assign accept    = mif.start & ((state == S_IDLE) | (state == S_DONE));
  assign last_iter = (state == S_MUL) && (count == CW'(WIDTH - 1));
  assign acc_mul   = acc + (mplier[0] ? mcand : '0);
  // Value that lands in acc on the edge into DONE (from MUL or ACC).
  assign acc_fin   = (state == S_ACC) ? (acc + rn_l) : acc_mul;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_MUL;
      S_MUL:   if (last_iter) state_nxt = acc_l ? S_ACC : S_DONE;
      S_ACC:   state_nxt = S_DONE;
      S_DONE:  state_nxt = mif.start ? S_MUL : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      rn_l   <= '0;
      count  <= '0;
      acc_l  <= 1'b0;
      s_l    <= 1'b0;
      c_l    <= 1'b0;
      v_l    <= 1'b0;
    end else if (accept) begin
      acc    <= '0;
      mcand  <= mif.op_rm;
      mplier <= mif.op_rs;
      rn_l   <= mif.op_rn;
      count  <= '0;
      acc_l  <= mif.accumulate;
      s_l    <= mif.s_bit;
      c_l    <= mif.c_in;
      v_l    <= mif.v_in;
    end else begin
      case (state)
        S_MUL: begin
          acc    <= acc_mul;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + CW'(1);
        end
        S_ACC:   acc <= acc_fin;
        default: ;
      endcase
    end
  end

  // Output registers load only on entry to DONE, so they hold through the
  // next op's MUL/ACC and are unaffected by a back-to-back accept in DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_q <= '0;
      n_q   <= 1'b0;
      z_q   <= 1'b0;
      c_q   <= 1'b0;
      v_q   <= 1'b0;
    end else if (state_nxt == S_DONE) begin
      res_q <= acc_fin;
      n_q   <= acc_fin[WIDTH-1];
      z_q   <= (acc_fin == '0);
      c_q   <= c_l;
      v_q   <= v_l;
    end
  end

  // busy includes the accept cycle so the front end stalls immediately.
  assign mif.busy         = (state == S_MUL) | (state == S_ACC) | accept;
  assign mif.done         = (state == S_DONE);
  assign mif.status_wb_en = (state == S_DONE) & s_l;
  assign mif.result       = res_q;
  assign mif.N            = n_q;
  assign mif.Z            = z_q;
  assign mif.C            = c_q;
  assign mif.V            = v_q;

endmodule

// File: tb/tb_exe_mul_unit.sv
// tb_exe_mul_unit
// Directed vectors with hand-computed products for exe_mul_unit (WIDTH=32).
// Inputs driven and outputs sampled on the falling edge.
module tb_exe_mul_unit;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  exe_mul_unit_if #(.WIDTH(WIDTH)) mif ();

  exe_mul_unit #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .mif (mif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic acc, input logic s, input logic [31:0] rm,
                         input logic [31:0] rs, input logic [31:0] rn,
                         input logic c, input logic v);
    mif.accumulate = acc;
    mif.s_bit      = s;
    mif.op_rm      = rm;
    mif.op_rs      = rs;
    mif.op_rn      = rn;
    mif.c_in       = c;
    mif.v_in       = v;
  endtask

  // Issue from a falling edge; lat = rising edges from accept edge
  // (inclusive) until done is seen, 0 on timeout.
  task automatic run_op(input logic acc, input logic s, input logic [31:0] rm,
                        input logic [31:0] rs, input logic [31:0] rn,
                        input logic c, input logic v, output int lat);
    int n;
    set_req(acc, s, rm, rs, rn, c, v);
    mif.start = 1'b1;
    #1 chk("busy_accept", {63'd0, mif.busy}, 64'd1);
    @(posedge clk);
    n = 1;
    @(negedge clk);
    mif.start = 1'b0;
    while (!mif.done && n < 100) begin
      @(posedge clk); n++;
      @(negedge clk);
    end
    lat = mif.done ? n : 0;
  endtask

  task automatic chk_flags(input string tag, input logic [3:0] nzcv);
    chk(tag, {60'd0, mif.N, mif.Z, mif.C, mif.V}, {60'd0, nzcv});
  endtask

  initial begin
    int lat, n, dones;
    logic busy_drop, res_moved;
    mif.start = 1'b0;
    set_req(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);

    // ---- reset ----
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'd0, mif.busy}, 64'd0);
    chk("rst_done", {63'd0, mif.done}, 64'd0);
    chk("rst_wb", {63'd0, mif.status_wb_en}, 64'd0);
    chk("rst_result", {32'd0, mif.result}, 64'd0);
    chk_flags("rst_flags", 4'b0000);
    rst = 1'b1;
    @(negedge clk);

    // ---- MUL 3*5, S=1, C=1, V=0 ----
    run_op(1'b0, 1'b1, 32'd3, 32'd5, 32'd0, 1'b1, 1'b0, lat);
    chk("mul_lat", lat, 64'd33);
    chk("mul_res", {32'd0, mif.result}, 64'h0000000F);
    chk_flags("mul_nzcv", 4'b0010);
    chk("mul_wb", {63'd0, mif.status_wb_en}, 64'd1);
    chk("mul_busy_done", {63'd0, mif.busy}, 64'd0);
    @(negedge clk);
    chk("mul_done_pulse", {63'd0, mif.done}, 64'd0);
    chk("mul_wb_pulse", {63'd0, mif.status_wb_en}, 64'd0);
    chk("mul_res_hold", {32'd0, mif.result}, 64'h0000000F);

    // ---- MLA 0xFFFFFFFF*2 + 3 wraps to 1 ----
    run_op(1'b1, 1'b1, 32'hFFFFFFFF, 32'd2, 32'd3, 1'b0, 1'b0, lat);
    chk("mla_lat", lat, 64'd34);
    chk("mla_res", {32'd0, mif.result}, 64'h00000001);
    chk_flags("mla_nzcv", 4'b0000);
    @(negedge clk);

    // ---- MUL by zero, S=0, V preserved ----
    run_op(1'b0, 1'b0, 32'h12345678, 32'd0, 32'd0, 1'b0, 1'b1, lat);
    chk("zero_lat", lat, 64'd33);
    chk("zero_res", {32'd0, mif.result}, 64'd0);
    chk_flags("zero_nzcv", 4'b0101);
    chk("zero_done", {63'd0, mif.done}, 64'd1);
    chk("zero_wb", {63'd0, mif.status_wb_en}, 64'd0);
    @(negedge clk);

    // ---- MUL 0x80000000*1 -> N ----
    run_op(1'b0, 1'b1, 32'h80000000, 32'd1, 32'd0, 1'b0, 1'b0, lat);
    chk("neg_res", {32'd0, mif.result}, 64'h80000000);
    chk_flags("neg_nzcv", 4'b1000);
    @(negedge clk);

    // ---- stray start mid-op is ignored: 6*7 with 100*100 poked at cycle 10 ----
    set_req(1'b0, 1'b1, 32'd6, 32'd7, 32'd0, 1'b0, 1'b0);
    mif.start = 1'b1;
    @(posedge clk);
    n = 1; dones = 0; busy_drop = 1'b0; res_moved = 1'b0;
    @(negedge clk);
    mif.start = 1'b0;
    while (!mif.done && n < 100) begin
      if (!mif.busy) busy_drop = 1'b1;
      if (mif.result !== 32'h80000000) res_moved = 1'b1;
      if (n == 10) begin
        set_req(1'b1, 1'b0, 32'd100, 32'd100, 32'd5, 1'b1, 1'b1);
        mif.start = 1'b1;
      end else begin
        mif.start = 1'b0;
      end
      @(posedge clk); n++;
      @(negedge clk);
    end
    mif.start = 1'b0;
    chk("ign_lat", mif.done ? n : 0, 64'd33);
    chk("ign_busy_cont", {63'd0, busy_drop}, 64'd0);
    chk("ign_res_held", {63'd0, res_moved}, 64'd0);
    chk("ign_res", {32'd0, mif.result}, 64'd42);
    chk_flags("ign_nzcv", 4'b0000);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mif.done) dones++;
    end
    chk("ign_one_done", dones, 64'd0);

    // ---- back-to-back: 11*13 then 0x10000*0x10001 with start held ----
    set_req(1'b0, 1'b1, 32'd11, 32'd13, 32'd0, 1'b0, 1'b0);
    mif.start = 1'b1;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    set_req(1'b0, 1'b0, 32'h00010000, 32'h00010001, 32'd0, 1'b1, 1'b1);
    while (!mif.done && n < 100) begin
      @(posedge clk); n++;
      @(negedge clk);
    end
    chk("b2b_lat1", mif.done ? n : 0, 64'd33);
    chk("b2b_res1", {32'd0, mif.result}, 64'h0000008F);
    chk("b2b_wb1", {63'd0, mif.status_wb_en}, 64'd1);
    chk("b2b_busy", {63'd0, mif.busy}, 64'd1);
    @(posedge clk);
    n = 1;
    @(negedge clk);
    mif.start = 1'b0;
    while (!mif.done && n < 100) begin
      @(posedge clk); n++;
      @(negedge clk);
    end
    chk("b2b_lat2", mif.done ? n : 0, 64'd33);
    chk("b2b_res2", {32'd0, mif.result}, 64'h00010000);
    chk_flags("b2b_nzcv2", 4'b0011);
    chk("b2b_wb2", {63'd0, mif.status_wb_en}, 64'd0);
    @(negedge clk);

    // ---- reset at MUL cycle 20 aborts ----
    set_req(1'b0, 1'b1, 32'h0000FFFF, 32'h0000FFFF, 32'd0, 1'b1, 1'b1);
    mif.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mif.start = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_busy", {63'd0, mif.busy}, 64'd0);
    chk("abort_done", {63'd0, mif.done}, 64'd0);
    chk("abort_res", {32'd0, mif.result}, 64'd0);
    chk_flags("abort_nzcv", 4'b0000);
    @(negedge clk);
    rst = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mif.done || mif.status_wb_en) dones++;
    end
    chk("abort_no_done", dones, 64'd0);

    run_op(1'b0, 1'b0, 32'd7, 32'd9, 32'd0, 1'b0, 1'b0, lat);
    chk("post_lat", lat, 64'd33);
    chk("post_res", {32'd0, mif.result}, 64'h0000003F);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end
endmodule
